switch_scan_ctrl: RTL
=====================

Name: switch_scan_ctrl

Overview:
Autonomous polling controller for the 8-bit switch PIO input port, an Avalon-MM slave with read latency 1.
- Periodically issues single-word reads to the PIO, debounces the sampled value and latches rising/falling edges into a capture register.
- Raises a maskable interrupt to the Nios II CPU on a debounced change.
- Exposes a small Avalon-MM register slave so software reads clean switch state instead of polling raw pins.

Parameters:
WIDTH, 8, number of switch bits taken from PIO readdata[WIDTH-1:0]
POLL_DIV, 50000, clk cycles between poll requests (1 ms at 50 MHz); legal range 4..2^20
DEBOUNCE_CNT, 4, consecutive identical samples required to accept a new value; legal range 2..15

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pio_address  out  2  master address to switch PIO; always 0
pio_read  out  1  master read strobe, one-cycle pulse
pio_readdata  in  32  PIO readdata, valid the cycle after pio_read
s_address  in  2  CPU slave register offset
s_read  in  1  CPU slave read strobe
s_write  in  1  CPU slave write strobe
s_writedata  in  32  CPU slave write data
s_readdata  out  32  CPU slave read data, registered, latency 1
irq  out  1  level interrupt, registered

Behaviour:
- Reset/clock: reset_n asynchronous, active-low; clock clk.
- Reset values:
  - Outputs: pio_read=0, pio_address=0, s_readdata=0, irq=0.
  - Internal: stable=0, candidate=0, match_cnt=0, edge_cap=0, irq_mask=0, enable=1, tick counter=0, FSM=IDLE.
- Tick counter:
  - Counts 0..POLL_DIV-1 while enable=1 and FSM=IDLE; tick at terminal count, then wraps to 0.
  - Held at 0 while enable=0.
- FSM:
  - IDLE: on tick -> REQ.
  - REQ: pio_read=1 for exactly one cycle -> CAP.
  - CAP: sample = pio_readdata[WIDTH-1:0] -> EVAL.
  - EVAL: debounce update -> IDLE.
  - Poll-to-update latency: 3 cycles after tick.
- Debounce (EVAL):
  - If sample != candidate: candidate <= sample, match_cnt <= 1.
  - Else: match_cnt saturates at DEBOUNCE_CNT.
  - When match_cnt reaches DEBOUNCE_CNT (including the cycle it becomes equal) and candidate != stable: stable <= candidate, edge_cap |= (stable ^ candidate).
  - Acceptance is one-shot per change; no re-fire while saturated and equal.
- Register map (word offsets):
  - 0 STABLE: RO, {0, stable}.
  - 1 CTRL: bit0 enable RW, bits[7:4] match_cnt RO, bits[9:8] FSM state RO.
  - 2 IRQ_MASK: RW, WIDTH bits.
  - 3 EDGE_CAP: read returns edge_cap; write-1-to-clear per bit.
  - Writes to RO fields are ignored.
- s_readdata: registered on the cycle after s_read; holds its value otherwise. Unused upper bits read 0.
- irq: registered |(edge_cap & irq_mask); asserts 1 cycle after edge_cap/irq_mask update.
- Boundary cases:
  - W1C and new edge on the same bit in the same cycle: set wins.
  - enable cleared mid-transaction (REQ/CAP/EVAL): transaction completes to IDLE, then no new ticks; stable/edge_cap are retained.
  - enable set: tick counter restarts from 0; debounce state is not reset.
  - Simultaneous s_read and s_write: both honoured; read returns the pre-write value.
  - Async reset mid-transaction: all state returns to reset values immediately; the PIO is stateless, so no recovery is needed.

Decomposition:
- Shared package switch_scan_pkg:
  - Register offset constants REG_STABLE=0, REG_CTRL=1, REG_IRQ_MASK=2, REG_EDGE_CAP=3.
  - FSM state encoding IDLE/REQ/CAP/EVAL (2-bit).
  - CTRL bit-position constants.
- Sub-module switch_debounce_core (parameters WIDTH, DEBOUNCE_CNT):
  - Inputs: sample, sample_valid (EVAL pulse).
  - Outputs: stable, match_cnt, change_pulse, change_bits.
  - Top level keeps the tick counter, FSM, register slave and edge/irq logic.

Test Plan:
- Use POLL_DIV=4, DEBOUNCE_CNT=3 for all scenarios.
- Reset then idle: pio_read pulses exactly once every 7 cycles (4 tick + 3 FSM); STABLE reads 0x00; irq=0.
- Switches held 0x5A for 3 polls with IRQ_MASK=0xFF: STABLE=0x5A after 3rd EVAL; EDGE_CAP=0x5A; irq=1 one cycle later.
- Bounce: switch pattern 0x01,0x00,0x01,0x01,0x01 across polls: STABLE stays 0x00 until 5th poll, then 0x01; EDGE_CAP bit0 set once.
- Write 0x02 to EDGE_CAP in the same cycle EVAL sets bit1: EDGE_CAP bit1 remains 1. Subsequent write 0x02 clears it; irq drops 1 cycle later.
- Clear CTRL.enable during REQ: CAP and EVAL still complete; no pio_read for 100 cycles. Re-enable: first pio_read after 4 idle cycles + 1.
- IRQ_MASK=0x00 with switch change to 0xFF: EDGE_CAP=0xFF and irq=0. Writing IRQ_MASK=0x80 drives irq=1 next cycle.

Source files
------------

// File: rtl/switch_scan_pkg.sv
// Purpose: shared register map, FSM encoding and CTRL field layout for the switch scanner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package switch_scan_pkg;

  typedef logic [1:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  // Word offsets of the CPU-visible registers
  localparam reg_addr_t REG_STABLE   = 2'd0;
  localparam reg_addr_t REG_CTRL     = 2'd1;
  localparam reg_addr_t REG_IRQ_MASK = 2'd2;
  localparam reg_addr_t REG_EDGE_CAP = 2'd3;

  // Poll sequencer states; the encoding is software-visible in CTRL[9:8]
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAP  = 2'd2,
    ST_EVAL = 2'd3
  } scan_state_t;

  // CTRL field positions
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CNT_LSB    = 4;
  localparam int CTRL_CNT_MSB    = 7;
  localparam int CTRL_STATE_LSB  = 8;
  localparam int CTRL_STATE_MSB  = 9;

  // Width of the debounce match counter (holds DEBOUNCE_CNT up to 15)
  localparam int CNT_W = 4;

  // Assemble the CTRL read word; unused bits read as zero
  function automatic word_t ctrl_word(input logic en,
                                      input logic [CNT_W-1:0] cnt,
                                      input scan_state_t st);
    word_t w;
    w = '0;
    w[CTRL_ENABLE_BIT]              = en;
    w[CTRL_CNT_MSB:CTRL_CNT_LSB]     = cnt;
    w[CTRL_STATE_MSB:CTRL_STATE_LSB] = st;
    return w;
  endfunction

endpackage

// File: rtl/switch_scan_ctrl_if.sv
// Purpose: single-word Avalon-MM bus (address/read/write/data) with master and slave views.
// Latency: readdata is valid one cycle after read for every user of this bus.
// Backpressure: none; no waitrequest, every strobe is accepted in its cycle.
interface switch_scan_ctrl_if;
  import switch_scan_pkg::*;

  reg_addr_t address;
  logic      read;
  logic      write;
  word_t     writedata;
  word_t     readdata;

  modport master (output address, output read, output write, output writedata,
                  input readdata);
  modport slave  (input address, input read, input write, input writedata,
                  output readdata);
endinterface

// File: rtl/switch_scan_ctrl_debounce.sv
// Purpose: debounce filter; accepts a new switch value after DEBOUNCE_CNT identical samples.
// Latency: stable updates on the clock edge that ends the accepting sample_valid cycle.
// Backpressure: none; a sample is consumed in every cycle sample_valid is high.
module switch_debounce_core
  import switch_scan_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] stable,
  output logic [CNT_W-1:0] match_cnt,
  output logic             change_pulse,
  output logic [WIDTH-1:0] change_bits
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(DEBOUNCE_CNT);

  logic [WIDTH-1:0] candidate;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;

  // Next match count and one-shot acceptance; acceptance only fires on the
  // sample that brings the count to SAT while the value differs from stable.
  always_comb begin
    cnt_nxt      = match_cnt;
    accept       = 1'b0;
    change_pulse = 1'b0;
    change_bits  = '0;
    if (sample != candidate) begin
      cnt_nxt = CNT_W'(1);
    end else if (match_cnt >= SAT) begin
      cnt_nxt = SAT;
    end else begin
      cnt_nxt = match_cnt + CNT_W'(1);
    end
    accept = sample_valid && (cnt_nxt == SAT) && (sample != stable);
    if (accept) begin
      change_pulse = 1'b1;
      change_bits  = stable ^ sample;
    end
  end

  // Candidate, match count and accepted value, updated once per evaluated sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate <= '0;
      match_cnt <= '0;
      stable    <= '0;
    end else if (sample_valid) begin
      candidate <= sample;
      match_cnt <= cnt_nxt;
      if (accept) begin
        stable <= sample;
      end
    end
  end

endmodule

// File: rtl/switch_scan_ctrl.sv
// Purpose: autonomous switch PIO poller with debounce, edge capture, maskable irq and CSR slave.
// Latency: PIO sample reaches stable 3 cycles after tick; CSR read data 1 cycle; irq 1 cycle after edge/mask.
// Backpressure: none; PIO and CPU buses have no waitrequest, all strobes complete in one cycle.
module switch_scan_ctrl
  import switch_scan_pkg::*;
#(
  parameter int WIDTH        = 8,      // switch bits taken from pio readdata, must be < 32
  parameter int POLL_DIV     = 50000,  // clk cycles between poll requests, 4..2^20
  parameter int DEBOUNCE_CNT = 4       // identical samples needed to accept, 2..15
) (
  input  logic                clk,
  input  logic                reset_n,
  switch_scan_ctrl_if.master  pio,
  switch_scan_ctrl_if.slave   s,
  output logic                irq
);

  localparam int TICK_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(POLL_DIV - 1);

  scan_state_t       state, state_nxt;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              pio_rd, cap_en, eval_en;

  logic [WIDTH-1:0]  sample_q;
  logic [WIDTH-1:0]  stable;
  logic [CNT_W-1:0]  match_cnt;
  logic              change_pulse;
  logic [WIDTH-1:0]  change_bits;

  logic              enable;
  logic [WIDTH-1:0]  irq_mask;
  logic [WIDTH-1:0]  edge_cap;
  logic [WIDTH-1:0]  edge_clr;
  logic [WIDTH-1:0]  edge_set;
  logic              wr_ctrl, wr_mask, wr_edge;
  word_t             rd_mux;
  word_t             rd_q;

  // Upper data bits beyond the switch field carry nothing of interest
  logic              unused_hi;
  assign unused_hi = ^{pio.readdata[31:WIDTH], s.writedata[31:WIDTH]};

  // Poll period only advances while enabled and idle, so the request
  // spacing is POLL_DIV idle cycles plus the three transaction cycles.
  assign tick = enable && (state == ST_IDLE) && (tick_cnt == TICK_LAST);

  // Tick counter: wraps on tick, parked at zero while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else if (state == ST_IDLE) begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sequencer next state and strobes; a started transaction always runs to IDLE
  always_comb begin
    state_nxt = state;
    pio_rd    = 1'b0;
    cap_en    = 1'b0;
    eval_en   = 1'b0;
    case (state)
      ST_IDLE: if (tick) state_nxt = ST_REQ;
      ST_REQ: begin
        pio_rd    = 1'b1;
        state_nxt = ST_CAP;
      end
      ST_CAP: begin
        cap_en    = 1'b1;
        state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        eval_en   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign pio.address   = '0;
  assign pio.read      = pio_rd;
  assign pio.write     = 1'b0;
  assign pio.writedata = '0;

  // Capture the PIO word in the cycle after the read strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q <= '0;
    end else if (cap_en) begin
      sample_q <= pio.readdata[WIDTH-1:0];
    end
  end

  switch_debounce_core #(
    .WIDTH        (WIDTH),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample       (sample_q),
    .sample_valid (eval_en),
    .stable       (stable),
    .match_cnt    (match_cnt),
    .change_pulse (change_pulse),
    .change_bits  (change_bits)
  );

  assign wr_ctrl  = s.write && (s.address == REG_CTRL);
  assign wr_mask  = s.write && (s.address == REG_IRQ_MASK);
  assign wr_edge  = s.write && (s.address == REG_EDGE_CAP);
  assign edge_clr = wr_edge ? s.writedata[WIDTH-1:0] : '0;
  assign edge_set = change_pulse ? change_bits : '0;

  // Software-writable control bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= 1'b1;
      irq_mask <= '0;
    end else begin
      if (wr_ctrl) enable   <= s.writedata[CTRL_ENABLE_BIT];
      if (wr_mask) irq_mask <= s.writedata[WIDTH-1:0];
    end
  end

  // Edge capture: write-1-to-clear, a new edge on the same bit wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~edge_clr) | edge_set;
    end
  end

  // Read mux over the current (pre-write) register values
  always_comb begin
    rd_mux = '0;
    case (s.address)
      REG_STABLE:   rd_mux[WIDTH-1:0] = stable;
      REG_CTRL:     rd_mux = ctrl_word(enable, match_cnt, state);
      REG_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      REG_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_cap;
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else if (s.read) begin
      rd_q <= rd_mux;
    end
  end

  assign s.readdata = rd_q;

  // Level interrupt from any unmasked captured edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_cap & irq_mask);
    end
  end

endmodule
